// File: rtl/pc_alu_exec_unit.sv
// Execute stage of the single-cycle MIPS datapath: PC+4, the branch-target adder and the main ALU
// with flags, plus a registered status stage holding last cycle's result and a sticky overflow.
module pc_alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_offset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             ovf_sticky
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpNor  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
  localparam logic [3:0] OpLui  = 4'b1011;

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt_signed;
  logic             lt_unsigned;

  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             ovf_sticky_q;
  logic             ovf_sticky_d;

  assign pc_plus4      = pc + WIDTH'(4);
  assign branch_target = pc_plus4 + {br_offset[WIDTH-3:0], 2'b00};

  assign add_full    = {1'b0, a} + {1'b0, b};
  assign diff        = a - b;
  assign add_ovf     = (a[Msb] == b[Msb]) && (add_full[Msb] != a[Msb]);
  assign sub_ovf     = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
  // Direct signed compare rather than the sign of a-b, so it stays correct when a-b overflows.
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    carry      = 1'b0;
    case (alu_op)
      OpAnd:  alu_result = a & b;
      OpOr:   alu_result = a | b;
      OpAdd: begin
        alu_result = add_full[WIDTH-1:0];
        overflow   = add_ovf;
        carry      = add_full[WIDTH];
      end
      OpXor:  alu_result = a ^ b;
      OpNor:  alu_result = ~(a | b);
      OpSll:  alu_result = b << shamt;
      OpSub: begin
        alu_result = diff;
        overflow   = sub_ovf;
        carry      = ~lt_unsigned;
      end
      OpSlt:  alu_result = {{(WIDTH-1){1'b0}}, lt_signed};
      OpSltu: alu_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OpSrl:  alu_result = b >> shamt;
      OpSra:  alu_result = $signed(b) >>> shamt;
      OpLui:  alu_result = {b[15:0], {(WIDTH-16){1'b0}}};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  assign result_d     = alu_result;
  assign zero_d       = zero;
  assign ovf_sticky_d = ovf_sticky_q | overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q     <= '0;
      zero_q       <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      result_q     <= result_d;
      zero_q       <= zero_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_pc_alu_exec_unit.sv
// Self-checking bench for pc_alu_exec_unit: directed steps then random ones, checked against an
// arithmetic reference model and a bench-held copy of the expected registered status.
module tb_pc_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0, br_offset = '0, a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic [3:0]  alu_op = '0;
  logic [31:0] pc_plus4, branch_target, alu_result, result_q;
  logic        zero, overflow, carry, zero_q, ovf_sticky;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_result_q;
  logic        exp_zero_q;
  logic        exp_sticky;

  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  pc_alu_exec_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .br_offset    (br_offset),
    .a            (a),
    .b            (b),
    .shamt        (shamt),
    .alu_op       (alu_op),
    .pc_plus4     (pc_plus4),
    .branch_target(branch_target),
    .alu_result   (alu_result),
    .zero         (zero),
    .overflow     (overflow),
    .carry        (carry),
    .result_q     (result_q),
    .zero_q       (zero_q),
    .ovf_sticky   (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: true integer arithmetic, flags from range checks.
  task automatic model(input logic [3:0] op, input logic [31:0] ma, input logic [31:0] mb,
                       input logic [4:0] sh, output logic [31:0] r, output logic ovf,
                       output logic cy);
    longint sa, sb, s;
    logic [63:0] u;
    sa  = $signed(ma);
    sb  = $signed(mb);
    r   = '0;
    ovf = 1'b0;
    cy  = 1'b0;
    case (op)
      4'd0: r = ma & mb;
      4'd1: r = ma | mb;
      4'd2: begin
        u   = {32'b0, ma} + {32'b0, mb};
        r   = u[31:0];
        cy  = (u > 64'hFFFF_FFFF);
        s   = sa + sb;
        ovf = (s > SMax) || (s < SMin);
      end
      4'd3: r = ma ^ mb;
      4'd4: r = ~(ma | mb);
      4'd5: r = mb << sh;
      4'd6: begin
        r   = ma - mb;
        cy  = (ma >= mb);
        s   = sa - sb;
        ovf = (s > SMax) || (s < SMin);
      end
      4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: r = (ma < mb) ? 32'd1 : 32'd0;
      4'd9: r = mb >> sh;
      4'd10: r = mb[31] ? ~((~mb) >> sh) : (mb >> sh);
      4'd11: r = (mb & 32'h0000_FFFF) << 16;
      default: r = '0;
    endcase
  endtask

  task automatic step(input string tag, input logic r_in, input logic [3:0] op,
                      input logic [31:0] va, input logic [31:0] vb, input logic [4:0] sh,
                      input logic [31:0] vpc, input logic [31:0] voff);
    logic [31:0] er;
    logic        eo, ec;
    logic [63:0] t;
    @(negedge clk);
    rst = r_in; alu_op = op; a = va; b = vb; shamt = sh; pc = vpc; br_offset = voff;
    #1;
    model(op, va, vb, sh, er, eo, ec);
    t = {32'b0, vpc} + 64'd4;
    chk({tag, ".pc_plus4"}, pc_plus4, t[31:0]);
    t = {32'b0, vpc} + 64'd4 + {32'b0, voff} * 64'd4;
    chk({tag, ".branch_target"}, branch_target, t[31:0]);
    chk({tag, ".alu_result"}, alu_result, er);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, er == 32'd0});
    chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, eo});
    chk({tag, ".carry"}, {31'b0, carry}, {31'b0, ec});
    @(posedge clk);
    #1;
    if (r_in) begin
      exp_result_q = '0;
      exp_zero_q   = 1'b0;
      exp_sticky   = 1'b0;
    end else begin
      exp_result_q = er;
      exp_zero_q   = (er == 32'd0);
      exp_sticky   = exp_sticky | eo;
    end
    chk({tag, ".result_q"}, result_q, exp_result_q);
    chk({tag, ".zero_q"}, {31'b0, zero_q}, {31'b0, exp_zero_q});
    chk({tag, ".ovf_sticky"}, {31'b0, ovf_sticky}, {31'b0, exp_sticky});
  endtask

  // Directed spot checks against literal values from the worked examples.
  task automatic lit(input string tag, input logic [3:0] op, input logic [31:0] va,
                     input logic [31:0] vb, input logic [4:0] sh, input logic [31:0] exp);
    @(negedge clk);
    rst = 1'b0; alu_op = op; a = va; b = vb; shamt = sh;
    #1;
    chk(tag, alu_result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_result_q = '0;
    exp_zero_q   = 1'b0;
    exp_sticky   = 1'b0;

    step("rst0", 1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0);
    step("rst1", 1'b1, 4'd0, 32'h1, 32'h1, 5'd0, 32'h0, 32'h0);

    step("pc_a", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 32'h0040_0000, 32'h0000_0003);
    chk("pc_a.lit_pc4", pc_plus4, 32'h0040_0004);
    chk("pc_a.lit_bt", branch_target, 32'h0040_0010);
    step("pc_wrap", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFC, 32'h0);
    chk("pc_wrap.lit", pc_plus4, 32'h0000_0000);
    step("pc_back", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 32'h0040_0008, 32'hFFFF_FFFF);
    chk("pc_back.lit", branch_target, 32'h0040_0008);

    // Overflowing ADD then AND: sticky must hold, result_q must lag by one edge.
    step("add_ovf", 1'b0, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0);
    chk("add_ovf.lit_rq", result_q, 32'h8000_0000);
    chk("add_ovf.lit_st", {31'b0, ovf_sticky}, 32'd1);
    step("and_after", 1'b0, 4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h0, 32'h0);
    chk("and_after.lit_st", {31'b0, ovf_sticky}, 32'd1);
    step("add_wrap", 1'b0, 4'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0);
    chk("add_wrap.lit_zq", {31'b0, zero_q}, 32'd1);
    step("sub_eq", 1'b0, 4'd6, 32'd5, 32'd5, 5'd0, 32'h0, 32'h0);
    step("slt_ovf", 1'b0, 4'd7, 32'h8000_0000, 32'd1, 5'd0, 32'h0, 32'h0);
    step("sltu", 1'b0, 4'd8, 32'h8000_0000, 32'd1, 5'd0, 32'h0, 32'h0);
    step("slt_eq", 1'b0, 4'd7, 32'd3, 32'd3, 5'd0, 32'h0, 32'h0);
    step("undef", 1'b0, 4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 32'h0, 32'h0);

    lit("lit_and", 4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0);
    lit("lit_or", 4'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFFF0_FFF0);
    lit("lit_xor", 4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFF00_FF00);
    lit("lit_nor", 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h000F_000F);
    lit("lit_sll", 4'd5, 32'h0, 32'd1, 5'd31, 32'h8000_0000);
    lit("lit_sra", 4'd10, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000);
    lit("lit_srl", 4'd9, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000);
    lit("lit_lui", 4'd11, 32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000);
    lit("lit_slt", 4'd7, 32'h8000_0000, 32'd1, 5'd0, 32'd1);
    lit("lit_sub", 4'd6, 32'd5, 32'd5, 5'd0, 32'd0);
    step("sync_a", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);

    // Reset in the same cycle as an overflowing ADD must win.
    step("ovf_set", 1'b0, 4'd6, 32'h8000_0000, 32'd1, 5'd0, 32'h0, 32'h0);
    chk("ovf_set.lit_st", {31'b0, ovf_sticky}, 32'd1);
    step("rst_ovf", 1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0);
    chk("rst_ovf.lit_st", {31'b0, ovf_sticky}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), pick(), pick(),
           5'($urandom), $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_alu_exec_unit.md
# pc_alu_exec_unit

Arithmetic execute stage of the single-cycle MIPS datapath. It combines three functions:

- the PC incrementer (PC+4);
- the branch-target adder (PC+4 plus the shifted word offset);
- the main 32-bit ALU with zero, overflow and carry flags.

All datapath results are combinational so the single-cycle core can close its loop in one clock. A small registered status stage captures the previous cycle's ALU result and a sticky overflow flag for debug and trap logic.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  input  32  current program counter.
- br_offset  input  32  sign-extended branch word offset (immediate already extended to 32 bits).
- a  input  32  ALU operand A (rs value).
- b  input  32  ALU operand B (rt value or extended immediate, chosen upstream).
- shamt  input  5  shift amount for SLL/SRL/SRA.
- alu_op  input  4  operation select.
- pc_plus4  output  32  pc + 4, combinational.
- branch_target  output  32  pc_plus4 + (br_offset << 2), combinational.
- alu_result  output  32  combinational ALU result.
- zero  output  1  high when alu_result == 0, combinational.
- overflow  output  1  signed overflow of ADD/SUB, combinational; low for all other ops.
- carry  output  1  unsigned carry-out of ADD, or no-borrow of SUB (a >= b unsigned), combinational; low for other ops.
- result_q  output  32  alu_result registered on the previous rising edge.
- zero_q  output  1  zero registered on the previous rising edge.
- ovf_sticky  output  1  sticky OR of overflow, cleared only by rst.

## Operation
- pc_plus4 = pc + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- branch_target = pc_plus4 + {br_offset[29:0], 2'b00}, modulo 2^32; negative offsets produce backward targets.
- alu_op encoding (result as a function of a, b, shamt):
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b.
  - 0011 XOR: a ^ b.
  - 0100 NOR: ~(a | b).
  - 0101 SLL: b << shamt.
  - 0110 SUB: a − b.
  - 0111 SLT: signed (a < b) ? 1 : 0.
  - 1000 SLTU: unsigned (a < b) ? 1 : 0.
  - 1001 SRL: b >> shamt, logical.
  - 1010 SRA: b >>> shamt, arithmetic.
  - 1011 LUI: {b[15:0], 16'h0000}.
  - 1100–1111: result 0x00000000, which also drives zero = 1.
- ADD/SUB wrap modulo 2^32 and never trap; overflow only flags the condition.
  - Overflow for ADD: operands share a sign and the result sign differs.
  - Overflow for SUB: operands differ in sign and the result sign differs from a.
- SLT compares correctly even when a − b would overflow (e.g. a=0x80000000, b=1 gives 1).
- zero is derived from alu_result for every op, so it is usable for BEQ (SUB) and BNE.
- Combinational outputs carry no dependency on clk or rst.

## Timing
- Combinational outputs: zero-cycle latency; they settle within the same cycle as their inputs.
- On each rising edge with rst=0:
  - result_q <= alu_result;
  - zero_q <= zero;
  - ovf_sticky <= ovf_sticky | overflow.
- On a rising edge with rst=1:
  - result_q = 0, zero_q = 0, ovf_sticky = 0;
  - rst takes priority over an overflow in the same cycle.
- Reset asserted mid-operation clears only the registered outputs; combinational outputs continue to track inputs.
- No handshake: the block accepts new inputs every cycle.

## Test plan
- PC path:
  - pc=0x00400000, br_offset=0x00000003 -> pc_plus4=0x00400004, branch_target=0x00400010.
  - pc=0xFFFFFFFC -> pc_plus4=0x00000000.
  - br_offset=0xFFFFFFFF with pc=0x00400008 -> branch_target=0x00400008.
- Arithmetic and flags:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1, carry=0.
  - ADD 0xFFFFFFFF+1 -> 0, zero=1, carry=1, overflow=0.
  - SUB 5−5 -> 0, zero=1.
- Compare:
  - SLT 0x80000000 vs 1 -> 1.
  - SLTU same operands -> 0.
  - SLT 3 vs 3 -> 0, zero=1.
- Logic and shift:
  - AND/OR/XOR/NOR on 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00 / 0x000F000F.
  - SLL b=1, shamt=31 -> 0x80000000.
  - SRA b=0x80000000, shamt=4 -> 0xF8000000.
  - SRL same -> 0x08000000.
  - LUI b=0x1234 -> 0x12340000.
  - Undefined op 1111 -> 0, zero=1.
- Registered status:
  - Hold rst=1 for 2 edges -> result_q=0, zero_q=0, ovf_sticky=0.
  - Then ADD overflow for one cycle followed by AND -> ovf_sticky stays 1 on later edges, and result_q lags alu_result by one edge.
  - Reassert rst in the same cycle as an overflowing ADD -> ovf_sticky=0 after that edge.
